// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl: bit-serial a - b sequencer built around one full-subtractor
// slice (two half-subtractors plus an OR of their borrows), LSB first, one bit
// per clock, framed by a start/done handshake.
// Optional feature: define SERIAL_SUB_ABS_EN to add the NEG state, which
// serially two's-complements a negative result so diff reports |a - b|.
module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bor
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd3;
`ifdef SERIAL_SUB_ABS_EN
  localparam logic [1:0] S_NEG  = 2'd2;
`endif

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_br;
  logic [CW-1:0]    r_cnt;
`ifdef SERIAL_SUB_ABS_EN
  logic             r_seen;   // a 1 has already passed through the negator
  logic             w_neg_bit;
`endif

  logic w_hs1_d;
  logic w_hs1_b;
  logic w_hs2_b;
  logic w_d;
  logic w_br_next;
  logic w_last;
  logic w_active;

  // Full subtractor: first half-subtractor takes a0 - b0, second subtracts the running borrow.
  assign w_hs1_d   = r_a[0] ^ r_b[0];
  assign w_hs1_b   = ~r_a[0] & r_b[0];
  assign w_d       = w_hs1_d ^ r_br;
  assign w_hs2_b   = ~w_hs1_d & r_br;
  assign w_br_next = w_hs1_b | w_hs2_b;

  assign w_last    = (r_cnt == CW'(WIDTH - 1));

`ifdef SERIAL_SUB_ABS_EN
  // Serial two's complement: copy bits through the first 1, invert afterwards.
  assign w_neg_bit = r_res[0] ^ r_seen;
  assign w_active  = (r_state == S_RUN) || (r_state == S_NEG);
`else
  assign w_active  = (r_state == S_RUN);
`endif

  // Sequencer: handshake, bit-serial datapath and registered outputs.
  // NOTE: every register here, shift registers included, is cleared by the
  // async reset so an aborted operation leaves nothing behind; all updates use
  // non-blocking assignments so the shift registers read pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_br    <= 1'b0;
      r_cnt   <= '0;
`ifdef SERIAL_SUB_ABS_EN
      r_seen  <= 1'b0;
`endif
      busy    <= 1'b0;
      done    <= 1'b0;
      diff    <= '0;
      bor     <= 1'b0;
    end else begin
      done <= 1'b0;
      busy <= w_active;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_res   <= '0;
            r_br    <= 1'b0;
            r_cnt   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_res <= {w_d, r_res[WIDTH-1:1]};
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_br  <= w_br_next;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_cnt   <= '0;
`ifdef SERIAL_SUB_ABS_EN
            r_seen  <= 1'b0;
            r_state <= w_br_next ? S_NEG : S_FIN;
`else
            r_state <= S_FIN;
`endif
          end
        end
`ifdef SERIAL_SUB_ABS_EN
        S_NEG: begin
          r_res  <= {w_neg_bit, r_res[WIDTH-1:1]};
          r_seen <= r_seen | r_res[0];
          r_cnt  <= r_cnt + CW'(1);
          if (w_last) begin
            r_cnt   <= '0;
            r_state <= S_FIN;
          end
        end
`endif
        S_FIN: begin
          diff    <= r_res;
          bor     <= r_br;
          done    <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Self-checking bench for serial_sub_ctrl (WIDTH=8). A transaction-level model
// predicts each result and its completion time from the arithmetic alone; a
// compare process checks every output on every falling edge. Directed cases
// pin the model with hand-computed literals. Honors SERIAL_SUB_ABS_EN.
module tb_serial_sub_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bor;

  int n_tests = 0;
  int n_fail  = 0;

  serial_sub_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bor   (bor)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

`ifdef SERIAL_SUB_ABS_EN
  localparam bit ABS = 1'b1;
`else
  localparam bit ABS = 1'b0;
`endif

  // ---------------- reference model ----------------
  int           m_left = 0;   // clocks until done appears; 0 means idle
  int           m_lat  = 0;   // latency of the operation in flight
  logic [W-1:0] m_pdiff = '0;
  logic         m_pbor  = 1'b0;
  logic [W-1:0] m_diff = '0;
  logic         m_bor  = 1'b0;
  logic         m_done = 1'b0;

  // Reference: result from plain arithmetic, latency WIDTH+1 or 2*WIDTH+1.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left <= 0;
      m_lat  <= 0;
      m_diff <= '0;
      m_bor  <= 1'b0;
      m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_left != 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_done <= 1'b1;
          m_diff <= m_pdiff;
          m_bor  <= m_pbor;
        end
      end else if (start) begin
        m_pbor  <= (a < b);
        if (ABS && (a < b)) begin
          m_pdiff <= W'(int'(b) - int'(a));
          m_left  <= 2 * W + 1;
          m_lat   <= 2 * W + 1;
        end else begin
          m_pdiff <= W'(int'(a) - int'(b));
          m_left  <= W + 1;
          m_lat   <= W + 1;
        end
      end
    end
  end

  // Every cycle out of reset, all four outputs must match the model.
  always @(negedge clk) begin
    if (rst_n) begin
      check("busy", 32'(busy), 32'((m_left != 0) && (m_left < m_lat)));
      check("done", 32'(done), 32'(m_done));
      check("diff", 32'(diff), 32'(m_diff));
      check("bor",  32'(bor),  32'(m_bor));
      if (busy && done) check("busy_and_done", 32'(1), 32'(0));
    end
  end

  // ---------------- directed helper ----------------
  // Issues one operation from an idle cycle (called #1 after a rising edge) and
  // measures latency to done. With hold=1, start stays high and a/b churn.
  task automatic run_op(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic [W-1:0] ed, input logic eb, input int elat, input bit hold);
    int lat;
    a = ta;
    b = tb_v;
    start = 1'b1;
    @(posedge clk);            // accept edge 0
    #1;
    if (!hold) start = 1'b0;
    lat = 0;
    while (lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) break;
      if (hold) begin
        a = W'($urandom);
        b = W'($urandom);
      end
    end
    check({nm, "_lat"},  32'(lat),  32'(elat));
    check({nm, "_diff"}, 32'(diff), 32'(ed));
    check({nm, "_bor"},  32'(bor),  32'(eb));
  endtask

  initial begin
    int lat_neg;
    lat_neg = ABS ? 2 * W + 1 : W + 1;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_diff", 32'(diff), 32'(0));
    check("rst_bor",  32'(bor),  32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed cases with hand-computed expectations.
    run_op("p5a_21", 8'h5A, 8'h21, 8'h39, 1'b0, 9, 1'b0);
    run_op("p10_20", 8'h10, 8'h20, ABS ? 8'h10 : 8'hF0, 1'b1, lat_neg, 1'b0);
    run_op("p00_ff", 8'h00, 8'hFF, ABS ? 8'hFF : 8'h01, 1'b1, lat_neg, 1'b0);
    run_op("pff_00", 8'hFF, 8'h00, 8'hFF, 1'b0, 9, 1'b0);

    // Reset during RUN cycle 4: outputs clear at once, no done follows.
    a = 8'h77;
    b = 8'h11;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'(0));
    check("mid_rst_done", 32'(done), 32'(0));
    check("mid_rst_diff", 32'(diff), 32'(0));
    check("mid_rst_bor",  32'(bor),  32'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) begin
      @(posedge clk);
      #1;
      check("mid_rst_no_done", 32'(done), 32'(0));
    end
    run_op("p03_01", 8'h03, 8'h01, 8'h02, 1'b0, 9, 1'b0);

    // start held high with churning operands, then back-to-back issue.
    run_op("hold", 8'hC3, 8'h3C, 8'h87, 1'b0, 9, 1'b1);
    run_op("b2b",  8'hAA, 8'hAA, 8'h00, 1'b0, 9, 1'b0);

    // Randomized traffic, including starts while busy and boundary operands.
    @(negedge clk);
    for (int i = 0; i < 1500; i++) begin
      start = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 7))
        0:       begin a = W'($urandom); b = a; end
        1:       begin a = '0; b = '1; end
        2:       begin a = '1; b = '0; end
        3:       begin a = '0; b = '0; end
        default: begin a = W'($urandom); b = W'($urandom); end
      endcase
      @(negedge clk);
    end
    start = 1'b0;
    repeat (40) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
